// File: rtl/fpp_pkg.sv
// Shared FP controller definitions: FSM states, opcode field positions, ALU function codes.
package fpp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Opcode layout: {func, src, dst}, dst in the LSBs
    localparam int unsigned FUNC_W  = 4;
    localparam int unsigned DST_LSB = 0;

    function automatic int unsigned src_lsb(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned func_lsb(input int unsigned aw);
        return 2 * aw;
    endfunction

    localparam logic [FUNC_W-1:0] FN_ADD = 4'h0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'h1;
    localparam logic [FUNC_W-1:0] FN_MUL = 4'h2;
    localparam logic [FUNC_W-1:0] FN_DIV = 4'h3;
    localparam logic [FUNC_W-1:0] FN_NEG = 4'h4;
    localparam logic [FUNC_W-1:0] FN_ABS = 4'h5;
    localparam logic [FUNC_W-1:0] FN_MOV = 4'h6;
    localparam logic [FUNC_W-1:0] FN_CMP = 4'h7;

endpackage

// File: rtl/fpp_regfile.sv
// NREG x W floating-point register file: two async read ports, one sync write port, sync reset.
module fpp_regfile #(
    parameter int unsigned W    = 16,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_a,
    output logic [W-1:0]  o_rdata_b
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/fpp_ctrl_n.sv
// Floating-point coprocessor controller: issues register operands to an external ALU and writes back.
// Optional ALU wait timeout enabled by defining FPP_TIMEOUT_EN.
module fpp_ctrl_n
    import fpp_pkg::*;
#(
    parameter int unsigned W           = 16,
    parameter int unsigned NREG        = 4,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned AW         = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FUNC_W+2*AW-1:0] opcode,
    input  logic                  op_valid,
    output logic                  op_ready,
    inout  wire  [W-1:0]          DataBus,
    output logic                  flag,
    output logic                  alu_st,
    output logic [W-1:0]          alu_rega,
    output logic [W-1:0]          alu_regb,
    output logic [FUNC_W-1:0]     alu_func,
    input  logic [W-1:0]          alu_result,
    input  logic                  alu_done,
    input  logic                  alu_flag_io,
    output logic                  err
);

    localparam int unsigned SRC_LSB  = src_lsb(AW);
    localparam int unsigned FUNC_LSB = func_lsb(AW);

    state_t              r_state;
    logic                r_op_ready;
    logic                r_alu_st;
    logic [W-1:0]        r_alu_rega;
    logic [W-1:0]        r_alu_regb;
    logic [FUNC_W-1:0]   r_alu_func;
    logic [AW-1:0]       r_dst;
    logic [W-1:0]        r_bus_value;

    logic [AW-1:0]       w_src;
    logic [AW-1:0]       w_dst;
    logic [FUNC_W-1:0]   w_func;
    logic [W-1:0]        w_rd_a;
    logic [W-1:0]        w_rd_b;
    logic                w_we;

    assign w_dst  = opcode[DST_LSB +: AW];
    assign w_src  = opcode[SRC_LSB +: AW];
    assign w_func = opcode[FUNC_LSB +: FUNC_W];

    // The only register write: ALU completion while waiting
    assign w_we = (r_state == S_WAIT) && alu_done;

    fpp_regfile #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (r_dst),
        .i_wdata   (alu_result),
        .i_raddr_a (w_src),
        .i_raddr_b (w_dst),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

`ifdef FPP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_ready  <= 1'b1;
            r_alu_st    <= 1'b0;
            r_alu_rega  <= '0;
            r_alu_regb  <= '0;
            r_alu_func  <= '0;
            r_dst       <= '0;
            r_bus_value <= '0;
`ifdef FPP_TIMEOUT_EN
            r_cnt       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_alu_st <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid && r_op_ready) begin
                        r_alu_func <= w_func;
                        r_dst      <= w_dst;
                        r_alu_rega <= w_rd_a;
                        r_alu_regb <= w_rd_b;
                        r_alu_st   <= 1'b1;
                        r_op_ready <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
`ifdef FPP_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (alu_done) begin
                        if (alu_flag_io) begin
                            r_bus_value <= alu_result;
                        end
                        r_state <= S_DRAIN;
                    end
`ifdef FPP_TIMEOUT_EN
                    // Abandon the operation without writeback once the wait limit is reached
                    else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_err      <= 1'b1;
                        r_op_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    if (!alu_done) begin
                        r_op_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_op_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FPP_TIMEOUT_EN
    assign err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT_CYC);
    assign err = 1'b0;
`endif

    assign op_ready = r_op_ready;
    assign alu_st   = r_alu_st;
    assign alu_rega = r_alu_rega;
    assign alu_regb = r_alu_regb;
    assign alu_func = r_alu_func;

    // The ALU owns the bus direction; we only drive while it asks us to
    assign DataBus = alu_flag_io ? r_bus_value : {W{1'bz}};
    assign flag    = alu_flag_io;

endmodule

// File: tb/tb_fpp_ctrl_n.sv
// Directed, table-driven bench for fpp_ctrl_n (W=16, NREG=4, TIMEOUT_CYC=8).
module tb_fpp_ctrl_n;

    localparam int unsigned W   = 16;
    localparam int unsigned AW  = 2;
    localparam int unsigned OPW = 4 + 2 * AW;
    localparam logic [W-1:0] IDLE_PAT = 16'hA5A5;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opcode;
    logic           op_valid;
    logic           op_ready;
    wire  [W-1:0]   DataBus;
    logic           flag;
    logic           alu_st;
    logic [W-1:0]   alu_rega;
    logic [W-1:0]   alu_regb;
    logic [3:0]     alu_func;
    logic [W-1:0]   alu_result;
    logic           alu_done;
    logic           alu_flag_io;
    logic           err;

    // Bench parks a known pattern on the bus whenever the controller must be high-Z
    assign DataBus = alu_flag_io ? {W{1'bz}} : IDLE_PAT;

    fpp_ctrl_n #(
        .W           (16),
        .NREG        (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .DataBus     (DataBus),
        .flag        (flag),
        .alu_st      (alu_st),
        .alu_rega    (alu_rega),
        .alu_regb    (alu_regb),
        .alu_func    (alu_func),
        .alu_result  (alu_result),
        .alu_done    (alu_done),
        .alu_flag_io (alu_flag_io),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_st   = 0;

    always @(posedge clk) begin
        if (alu_st) n_st++;
    end

    typedef struct {
        logic [3:0]    func;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [W-1:0]  res;
        logic          fl;
        logic [W-1:0]  exp_a;
        logic [W-1:0]  exp_b;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        if (!op_ready) chk({nm, " ready timeout"}, 32'(op_ready), 32'd1);
    endtask

    // Present one opcode; returns one cycle after acceptance (START)
    task automatic issue(input string nm, input logic [3:0] f, input logic [AW-1:0] s, input logic [AW-1:0] d);
        wait_ready(nm);
        opcode   = {f, s, d};
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    // From START: wait, return the ALU result 3 cycles later, drain back to IDLE
    task automatic finish_op(input string nm, input logic [W-1:0] res, input logic fl);
        tick();
        chk({nm, " alu_st low"}, 32'(alu_st), 32'd0);
        chk({nm, " busy"}, 32'(op_ready), 32'd0);
        repeat (2) tick();
        alu_done    = 1'b1;
        alu_result  = res;
        alu_flag_io = fl;
        tick();
        if (fl) begin
            chk({nm, " DataBus"}, 32'(DataBus), 32'(res));
            chk({nm, " flag hi"}, 32'(flag), 32'd1);
        end
        alu_done    = 1'b0;
        alu_flag_io = 1'b0;
        alu_result  = '0;
        #1;
        chk({nm, " bus released"}, 32'(DataBus), 32'(IDLE_PAT));
        chk({nm, " flag lo"}, 32'(flag), 32'd0);
        tick();
        chk({nm, " ready again"}, 32'(op_ready), 32'd1);
    endtask

    task automatic start_chk(input string nm, input logic [3:0] f, input logic [W-1:0] ea, input logic [W-1:0] eb);
        chk({nm, " alu_st"}, 32'(alu_st), 32'd1);
        chk({nm, " rega"}, 32'(alu_rega), 32'(ea));
        chk({nm, " regb"}, 32'(alu_regb), 32'(eb));
        chk({nm, " func"}, 32'(alu_func), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        tbl[0] = '{4'd1,  2'd1, 2'd2, 16'h3C00, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{4'd2,  2'd2, 2'd3, 16'h4000, 1'b1, 16'h3C00, 16'h0000};
        tbl[2] = '{4'd3,  2'd3, 2'd3, 16'h4200, 1'b0, 16'h4000, 16'h4000};
        tbl[3] = '{4'd4,  2'd0, 2'd1, 16'h4400, 1'b1, 16'h0000, 16'h0000};
        tbl[4] = '{4'd15, 2'd1, 2'd0, 16'h7BFF, 1'b0, 16'h4400, 16'h0000};
        tbl[5] = '{4'd0,  2'd3, 2'd0, 16'h0001, 1'b0, 16'h4200, 16'h7BFF};

        rst = 1'b1; opcode = '0; op_valid = 1'b0;
        alu_result = '0; alu_done = 1'b0; alu_flag_io = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset op_ready", 32'(op_ready), 32'd1);
        chk("reset alu_st", 32'(alu_st), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rega", 32'(alu_rega), 32'd0);
        chk("reset regb", 32'(alu_regb), 32'd0);
        chk("reset func", 32'(alu_func), 32'd0);
        chk("reset bus", 32'(DataBus), 32'(IDLE_PAT));

        for (int i = 0; i < 6; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(nm, tbl[i].func, tbl[i].src, tbl[i].dst);
            start_chk(nm, tbl[i].func, tbl[i].exp_a, tbl[i].exp_b);
            finish_op(nm, tbl[i].res, tbl[i].fl);
        end
        // FP = {0001, 4400, 3C00, 4200}

        // op_valid held high across a transaction: second accept only after alu_done falls
        wait_ready("hold");
        n0 = n_st;
        opcode = {4'd6, 2'd1, 2'd2};
        op_valid = 1'b1;
        tick();
        start_chk("hold1", 4'd6, 16'h4400, 16'h3C00);
        repeat (2) tick();
        alu_done = 1'b1; alu_result = 16'h1111;
        tick();
        repeat (2) begin
            tick();
            chk("hold drain busy", 32'(op_ready), 32'd0);
        end
        chk("hold drain no start", 32'(alu_st), 32'd0);
        alu_done = 1'b0;
        tick();
        chk("hold idle ready", 32'(op_ready), 32'd1);
        tick();
        start_chk("hold2", 4'd6, 16'h4400, 16'h1111);
        op_valid = 1'b0;
        finish_op("hold2", 16'h2222, 1'b0);
        chk("hold accept count", 32'(n_st - n0), 32'd2);
        issue("hold rd", 4'd7, 2'd2, 2'd0);
        start_chk("hold rd", 4'd7, 16'h2222, 16'h0001);
        finish_op("hold rd", 16'h5555, 1'b0);
        // FP = {5555, 4400, 2222, 4200}

        // alu_done in IDLE and START is ignored
        alu_done = 1'b1; alu_result = 16'hDEAD;
        repeat (2) tick();
        chk("idle done ignored", 32'(op_ready), 32'd1);
        chk("idle done no st", 32'(alu_st), 32'd0);
        opcode = {4'd5, 2'd3, 2'd1};
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        start_chk("start done", 4'd5, 16'h4200, 16'h4400);
        tick();
        alu_done = 1'b0; alu_result = '0;
        tick();
        chk("start done still waiting", 32'(op_ready), 32'd0);
        alu_done = 1'b1; alu_result = 16'h6666;
        tick();
        alu_done = 1'b0;
        tick();
        chk("start done ready", 32'(op_ready), 32'd1);
        issue("start rd", 4'd2, 2'd1, 2'd3);
        start_chk("start rd", 4'd2, 16'h6666, 16'h4200);
        finish_op("start rd", 16'h7777, 1'b0);
        // FP = {5555, 6666, 2222, 7777}

`ifdef FPP_TIMEOUT_EN
        issue("tmo", 4'd1, 2'd0, 2'd1);
        start_chk("tmo", 4'd1, 16'h5555, 16'h6666);
        tick();
        repeat (7) begin
            tick();
            chk("tmo err early", 32'(err), 32'd0);
        end
        chk("tmo busy", 32'(op_ready), 32'd0);
        tick();
        chk("tmo err set", 32'(err), 32'd1);
        chk("tmo ready", 32'(op_ready), 32'd1);
        issue("tmo rd", 4'd1, 2'd1, 2'd1);
        start_chk("tmo rd", 4'd1, 16'h6666, 16'h6666);
        finish_op("tmo rd", 16'h1234, 1'b0);
        chk("tmo err sticky", 32'(err), 32'd1);
`else
        issue("notmo", 4'd1, 2'd0, 2'd1);
        start_chk("notmo", 4'd1, 16'h5555, 16'h6666);
        repeat (20) tick();
        chk("notmo still waiting", 32'(op_ready), 32'd0);
        chk("notmo err", 32'(err), 32'd0);
        alu_done = 1'b1; alu_result = 16'h1234;
        tick();
        alu_done = 1'b0;
        tick();
        chk("notmo ready", 32'(op_ready), 32'd1);
        issue("notmo rd", 4'd1, 2'd1, 2'd1);
        start_chk("notmo rd", 4'd1, 16'h1234, 16'h1234);
        finish_op("notmo rd", 16'h1234, 1'b0);
        chk("notmo err end", 32'(err), 32'd0);
`endif

        // Reset pulsed mid-WAIT aborts without writeback and clears everything
        issue("rstw", 4'd3, 2'd2, 2'd3);
        start_chk("rstw", 4'd3, 16'h2222, 16'h7777);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw ready", 32'(op_ready), 32'd1);
        chk("rstw err", 32'(err), 32'd0);
        chk("rstw st", 32'(alu_st), 32'd0);
        chk("rstw rega", 32'(alu_rega), 32'd0);
        chk("rstw regb", 32'(alu_regb), 32'd0);
        chk("rstw func", 32'(alu_func), 32'd0);
        alu_done = 1'b1; alu_result = 16'hBEEF; alu_flag_io = 1'b1;
        #1;
        chk("rstw bus cleared", 32'(DataBus), 32'd0);
        tick();
        chk("rstw done ignored", 32'(op_ready), 32'd1);
        alu_done = 1'b0; alu_flag_io = 1'b0; alu_result = '0;
        tick();
        issue("rstw rd01", 4'd0, 2'd0, 2'd1);
        start_chk("rstw rd01", 4'd0, 16'h0000, 16'h0000);
        finish_op("rstw rd01", 16'h0000, 1'b0);
        issue("rstw rd23", 4'd0, 2'd2, 2'd3);
        start_chk("rstw rd23", 4'd0, 16'h0000, 16'h0000);
        finish_op("rstw rd23", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
